// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer
//   Hunts for SYNC_BYTE in the UART byte stream and parses frames of the form
//   SYNC, LEN, P[0..LEN-1], CHK (CHK = ~(LEN + sum of payload), mod 256).
//   A validated payload is held in an internal buffer. It stays there until
//   the consumer acks it. Bad frames are dropped and reported with
//   single-cycle error pulses.
//
//   Ports:
//     clk, rst            clock, asynchronous active-high reset
//     rx_vld, rx_data     one-cycle byte strobe from the UART core
//     pkt_rdy, pkt_len    a validated packet is held / its payload length
//     rd_addr, rd_data    random-access payload read, 1-cycle latency,
//                         reads at or beyond pkt_len return 0
//     pkt_ack             releases the held packet (sampled only in HOLD)
//     len_err, chk_err    error pulses: illegal length / checksum mismatch
//     to_err              inter-byte timeout pulse (0 unless enabled)
//     drop_cnt            bytes discarded while holding, saturates at 255
//
//   Build option: define UART_RX_TIMEOUT_EN to enable the inter-byte timeout
//   (TIMEOUT_CYC idle cycles while inside a frame abandons it).

module uart_rx_deframer #(
    parameter int unsigned MAX_LEN     = 32,
    parameter int unsigned AW          = 5,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter int unsigned TIMEOUT_CYC = 50000,
    parameter int unsigned TO_CNT_BIT  = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx_vld,
    input  logic [7:0]    rx_data,
    output logic          pkt_rdy,
    output logic [7:0]    pkt_len,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    input  logic          pkt_ack,
    output logic          len_err,
    output logic          chk_err,
    output logic          to_err,
    output logic [7:0]    drop_cnt
);

    typedef enum logic [2:0] {ST_IDLE, ST_LEN, ST_DATA, ST_CHK, ST_HOLD} state_t;

    localparam int unsigned DEPTH     = 1 << AW;
    localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

    state_t     state_q, state_d;
    logic [7:0] len_q, len_d;
    logic [7:0] sum_q, sum_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] buf_q [DEPTH];
    logic [7:0] buf_d [DEPTH];
    logic       pkt_rdy_q, pkt_rdy_d;
    logic [7:0] pkt_len_q, pkt_len_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic       len_err_q, len_err_d;
    logic       chk_err_q, chk_err_d;
    logic       to_err_q, to_err_d;
    logic [7:0] drop_q, drop_d;
    logic       to_expire;

`ifdef UART_RX_TIMEOUT_EN
    localparam logic [TO_CNT_BIT-1:0] TO_LAST = TO_CNT_BIT'(TIMEOUT_CYC - 1);

    logic [TO_CNT_BIT-1:0] to_cnt_q, to_cnt_d;
    logic                  to_wait;

    // Counts idle cycles inside a frame; any byte restarts the count, and a
    // byte arriving on the expiry cycle takes priority over the timeout.
    always_comb begin
        to_wait   = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CHK);
        to_expire = to_wait && !rx_vld && (to_cnt_q == TO_LAST);
        to_cnt_d  = '0;
        if (to_wait && !rx_vld && !to_expire) begin
            to_cnt_d = to_cnt_q + TO_CNT_BIT'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    logic unused_cfg;
    assign to_expire  = 1'b0;
    assign unused_cfg = ^{32'(TIMEOUT_CYC), 32'(TO_CNT_BIT)};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        sum_d     = sum_q;
        idx_d     = idx_q;
        buf_d     = buf_q;
        pkt_len_d = pkt_len_q;
        drop_d    = drop_q;
        len_err_d = 1'b0;
        chk_err_d = 1'b0;
        to_err_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (rx_vld && (rx_data == SYNC_BYTE)) begin
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (rx_vld) begin
                    if ((rx_data == 8'd0) || (rx_data > MAX_LEN_B)) begin
                        len_err_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        len_d   = rx_data;
                        sum_d   = rx_data;
                        idx_d   = '0;
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (rx_vld) begin
                    buf_d[idx_q[AW-1:0]] = rx_data;
                    sum_d = sum_q + rx_data;
                    idx_d = idx_q + 8'd1;
                    if (idx_q == (len_q - 8'd1)) begin
                        state_d = ST_CHK;
                    end
                end
            end
            ST_CHK: begin
                if (rx_vld) begin
                    if (rx_data == ~sum_q) begin
                        pkt_len_d = len_q;
                        state_d   = ST_HOLD;
                    end else begin
                        chk_err_d = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
            end
            ST_HOLD: begin
                if (rx_vld && (drop_q != 8'hFF)) begin
                    drop_d = drop_q + 8'd1;
                end
                if (pkt_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (to_expire) begin
            state_d  = ST_IDLE;
            to_err_d = 1'b1;
        end

        pkt_rdy_d = (state_d == ST_HOLD);
        rd_data_d = (9'(rd_addr) < {1'b0, pkt_len_q}) ? buf_q[rd_addr] : 8'h00;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q     <= '0;
            sum_q     <= '0;
            idx_q     <= '0;
            buf_q     <= '{default: '0};
            pkt_rdy_q <= 1'b0;
            pkt_len_q <= '0;
            rd_data_q <= '0;
            len_err_q <= 1'b0;
            chk_err_q <= 1'b0;
            to_err_q  <= 1'b0;
            drop_q    <= '0;
        end else begin
            len_q     <= len_d;
            sum_q     <= sum_d;
            idx_q     <= idx_d;
            buf_q     <= buf_d;
            pkt_rdy_q <= pkt_rdy_d;
            pkt_len_q <= pkt_len_d;
            rd_data_q <= rd_data_d;
            len_err_q <= len_err_d;
            chk_err_q <= chk_err_d;
            to_err_q  <= to_err_d;
            drop_q    <= drop_d;
        end
    end

    assign pkt_rdy  = pkt_rdy_q;
    assign pkt_len  = pkt_len_q;
    assign rd_data  = rd_data_q;
    assign len_err  = len_err_q;
    assign chk_err  = chk_err_q;
    assign to_err   = to_err_q;
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Randomised frame-level bench for uart_rx_deframer. Stimulus is generated as
// whole frames (good, bad checksum, bad length, junk); the expected outcome of
// each frame is computed from the frame rules directly.

module tb_uart_rx_deframer;

    localparam int          MAX_LEN = 32;
    localparam int          AW      = 5;
    localparam int          DEPTH   = 1 << AW;
    localparam logic [7:0]  SYNC    = 8'hA5;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_vld;
    logic [7:0]    rx_data;
    logic          pkt_rdy;
    logic [7:0]    pkt_len;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          pkt_ack;
    logic          len_err;
    logic          chk_err;
    logic          to_err;
    logic [7:0]    drop_cnt;

    always #5 clk = ~clk;

    uart_rx_deframer #(
        .MAX_LEN    (MAX_LEN),
        .AW         (AW),
        .SYNC_BYTE  (SYNC),
        .TIMEOUT_CYC(100),
        .TO_CNT_BIT (16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rx_vld  (rx_vld),
        .rx_data (rx_data),
        .pkt_rdy (pkt_rdy),
        .pkt_len (pkt_len),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .pkt_ack (pkt_ack),
        .len_err (len_err),
        .chk_err (chk_err),
        .to_err  (to_err),
        .drop_cnt(drop_cnt)
    );

    int total = 0;
    int bad   = 0;

    // Expected totals of error pulses and the expected drop counter.
    int exp_len_n = 0;
    int exp_chk_n = 0;
    int exp_drop  = 0;
    int n_len = 0;
    int n_chk = 0;
    int n_to  = 0;

    logic [7:0] pl [256];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (len_err) n_len++;
            if (chk_err) n_chk++;
            if (to_err)  n_to++;
        end
    end

    // Drives one byte strobe; returns at the following negedge with rx_vld
    // still high so the next byte may follow back-to-back.
    task automatic send(input logic [7:0] b);
        rx_vld  = 1'b1;
        rx_data = b;
        @(negedge clk);
    endtask

    task automatic gap(input int n);
        rx_vld = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_g(input logic [7:0] b);
        send(b);
        if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 2));
    endtask

    function automatic logic [7:0] frame_chk(input int len);
        int s = len;
        for (int i = 0; i < len; i++) s += int'(pl[i]);
        return ~8'(s);
    endfunction

    function automatic logic [7:0] junk_byte();
        logic [7:0] b = 8'($urandom);
        if (b == SYNC) b = 8'h00;
        return b;
    endfunction

    task automatic fill_payload(input int len);
        for (int i = 0; i < len; i++) pl[i] = 8'($urandom);
    endtask

    // Checks a just-completed good frame: ready/length, drops while held,
    // full read-back of the buffer, then release with an optional byte in the
    // ack cycle and a multi-cycle ack.
    task automatic finish_good(input int len, input int n_drop, input bit ack_vld);
        int ack_cyc;
        check("rdy_rise", 32'(pkt_rdy), 32'd1);
        check("len", 32'(pkt_len), 32'(len));
        gap(0);
        for (int k = 0; k < n_drop; k++) begin
            send(8'($urandom));
            if (exp_drop < 255) exp_drop++;
        end
        gap(1);
        check("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr = AW'(a);
            @(negedge clk);
            check($sformatf("rd[%0d]", a), 32'(rd_data), (a < len) ? 32'(pl[a]) : 32'd0);
        end
        check("rdy_hold", 32'(pkt_rdy), 32'd1);
        ack_cyc = $urandom_range(1, 3);
        pkt_ack = 1'b1;
        if (ack_vld) begin
            rx_vld  = 1'b1;
            rx_data = SYNC;
            if (exp_drop < 255) exp_drop++;
        end
        @(negedge clk);
        rx_vld = 1'b0;
        check("rdy_fall", 32'(pkt_rdy), 32'd0);
        repeat (ack_cyc - 1) @(negedge clk);
        pkt_ack = 1'b0;
        check("drop_after_ack", 32'(drop_cnt), 32'(exp_drop));
        check("rdy_low", 32'(pkt_rdy), 32'd0);
    endtask

    task automatic do_good(input int len, input int n_drop, input bit ack_vld);
        logic [7:0] c;
        c = frame_chk(len);
        send_g(SYNC);
        send_g(8'(len));
        for (int i = 0; i < len; i++) send_g(pl[i]);
        send(c);
        check("good_no_chk_err", 32'(chk_err), 32'd0);
        finish_good(len, n_drop, ack_vld);
    endtask

    task automatic do_bad_chk(input int len, input logic [7:0] c);
        send_g(SYNC);
        send_g(8'(len));
        for (int i = 0; i < len; i++) send_g(pl[i]);
        send(c);
        exp_chk_n++;
        check("chk_err_pulse", 32'(chk_err), 32'd1);
        check("chk_rdy_low", 32'(pkt_rdy), 32'd0);
        gap(1);
        check("chk_err_one", 32'(chk_err), 32'd0);
    endtask

    task automatic do_bad_len(input logic [7:0] l);
        send_g(SYNC);
        send(l);
        exp_len_n++;
        check("len_err_pulse", 32'(len_err), 32'd1);
        gap(1);
        check("len_err_one", 32'(len_err), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int len;
        int kind;
        int to_seen;
        logic [7:0] c;

        rst = 1'b1; rx_vld = 1'b0; rx_data = '0; pkt_ack = 1'b0; rd_addr = '0;
        repeat (3) @(negedge clk);
        check("rst_rdy", 32'(pkt_rdy), 32'd0);
        check("rst_len", 32'(pkt_len), 32'd0);
        check("rst_rd", 32'(rd_data), 32'd0);
        check("rst_errs", 32'({len_err, chk_err, to_err}), 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed frame from the wire format description.
        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
        check("chk_formula", 32'(frame_chk(3)), 32'h96);
        do_good(3, 0, 1'b0);

        // Leading junk followed by a bad checksum, then a good frame.
        send(8'h00); send(8'hFF);
        pl[0] = 8'h10; pl[1] = 8'h20;
        do_bad_chk(2, 8'h00);
        fill_payload(5);
        do_good(5, 1, 1'b1);

        // Length boundaries.
        do_bad_len(8'h00);
        do_bad_len(8'(MAX_LEN + 1));
        do_bad_len(SYNC);
        for (int i = 0; i < 1; i++) pl[i] = 8'h5A;
        do_good(1, 0, 1'b0);
        for (int i = 0; i < MAX_LEN; i++) pl[i] = 8'h01;
        do_good(MAX_LEN, 0, 1'b0);

        // Randomised mix of frames.
        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 5);
            len  = $urandom_range(1, MAX_LEN);
            case (kind)
                0, 1, 2: begin
                    fill_payload(len);
                    do_good(len, $urandom_range(0, 3), 1'($urandom));
                end
                3: begin
                    fill_payload(len);
                    c = frame_chk(len) ^ 8'($urandom_range(1, 255));
                    do_bad_chk(len, c);
                end
                4: begin
                    if ($urandom_range(0, 1) == 0) do_bad_len(8'h00);
                    else do_bad_len(8'($urandom_range(MAX_LEN + 1, 255)));
                end
                default: begin
                    repeat ($urandom_range(1, 4)) send(junk_byte());
                    gap($urandom_range(0, 2));
                end
            endcase
        end

        // Drop counter saturation with the buffer left intact.
        fill_payload(7);
        do_good(7, 300, 1'b1);
        check("drop_sat", 32'(drop_cnt), 32'd255);

        // Reset in the middle of a frame abandons it and clears the counter.
        send(SYNC); send(8'd5); send(8'h11);
        rst = 1'b1;
        rx_vld = 1'b0;
        @(negedge clk);
        exp_drop = 0;
        check("mid_rst_drop", 32'(drop_cnt), 32'd0);
        check("mid_rst_rdy", 32'(pkt_rdy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        fill_payload(4);
        do_good(4, 2, 1'b0);

        // Long idle inside a frame.
        fill_payload(4);
        pl[0] = 8'hAA;
        send(SYNC); send(8'd4); send(pl[0]);
        rx_vld = 1'b0;
        to_seen = 0;
        repeat (110) begin
            @(negedge clk);
            if (to_err) to_seen++;
        end
`ifdef UART_RX_TIMEOUT_EN
        check("to_pulses", 32'(to_seen), 32'd1);
        fill_payload(6);
        do_good(6, 0, 1'b0);
`else
        check("to_pulses", 32'(to_seen), 32'd0);
        send(pl[1]); send(pl[2]); send(pl[3]);
        send(frame_chk(4));
        finish_good(4, 0, 1'b0);
`endif

        gap(3);
        check("len_err_total", 32'(n_len), 32'(exp_len_n));
        check("chk_err_total", 32'(n_chk), 32'(exp_chk_n));
`ifdef UART_RX_TIMEOUT_EN
        check("to_err_total", 32'(n_to), 32'd1);
`else
        check("to_err_total", 32'(n_to), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
